ones_counter_seq: RTL

- Sequential, parametrised successor to the 3-input combinational ones-counter (OC_y0/OC_y1).
- Counts the 1-bits in a WIDTH-bit word, consuming STEP bits per clock under a start/busy/done handshake.
- Accumulates a running total across words and provides a sticky overflow flag.
- Used wherever a popcount of wide data is needed without a large combinational adder tree.

---
 rtl/ones_counter_seq_if.sv | 45 ++++
 rtl/ones_counter_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ones_counter_seq_if.sv
// ----------------------------------------------------------------------------
// ones_counter_seq_if
// Handshake/result bundle for the sequential ones-counter.
//   master : drives start, din, clr_total; observes busy, done, count,
//            total, total_ovf (and maj when ONES_COUNTER_MAJORITY_EN is set)
//   slave  : the counter itself (mirror directions)
// Optional feature macro: ONES_COUNTER_MAJORITY_EN adds the maj signal.
// Parameters must match those of the attached ones_counter_seq instance.
// ----------------------------------------------------------------------------
interface ones_counter_seq_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] din;
    logic             clr_total;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;
    logic [ACC_W-1:0] total;
    logic             total_ovf;
`ifdef ONES_COUNTER_MAJORITY_EN
    logic             maj;

    modport master (
        output start, din, clr_total,
        input  busy, done, count, total, total_ovf, maj
    );
    modport slave (
        input  start, din, clr_total,
        output busy, done, count, total, total_ovf, maj
    );
`else
    modport master (
        output start, din, clr_total,
        input  busy, done, count, total, total_ovf
    );
    modport slave (
        input  start, din, clr_total,
        output busy, done, count, total, total_ovf
    );
`endif
endinterface

// File: rtl/ones_counter_seq.sv
// ----------------------------------------------------------------------------
// ones_counter_seq
// Sequential popcount: counts the 1-bits of a WIDTH-bit word, STEP bits per
// clock, under a start/busy/done handshake. Completed counts accumulate into
// a modulo-2^ACC_W running total with a sticky wrap flag.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - ones_counter_seq_if.slave:
//            start     in   request to count din (accepted in IDLE or DONE)
//            din       in   word, captured only on an accepted start
//            clr_total in   synchronous clear of total/total_ovf (wins over
//                           a coincident accumulate)
//            busy      out  high while counting
//            done      out  one-cycle pulse, count/total are final
//            count     out  ones in the last completed word
//            total     out  running sum of completed counts
//            total_ovf out  sticky, set when a total addition wraps
//            maj       out  (ONES_COUNTER_MAJORITY_EN only) count > WIDTH/2
//
// Optional feature macro: ONES_COUNTER_MAJORITY_EN.
// Constraints: WIDTH >= 2, STEP divides WIDTH, ACC_W >= $clog2(WIDTH+1).
// ----------------------------------------------------------------------------
module ones_counter_seq #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int ACC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    ones_counter_seq_if.slave bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    acc_q;
    logic [SW-1:0]    step_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    count_q;
    logic [ACC_W-1:0] total_q;
    logic             ovf_q;
`ifdef ONES_COUNTER_MAJORITY_EN
    logic             maj_q;
`endif

    function automatic logic [CW-1:0] pop_grp(input logic [STEP-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < STEP; i++) c = c + {{(CW-1){1'b0}}, v[i]};
        return c;
    endfunction

    logic [CW-1:0]  acc_d;
    logic           last_grp;
    logic [ACC_W:0] sum_w;

    // acc_d is the count including the group consumed at this edge; on the
    // final group it is the finished word count.
    assign acc_d    = acc_q + pop_grp(shreg_q[STEP-1:0]);
    assign last_grp = (step_q == SW'(N - 1));
    // Extra top bit is the carry-out that feeds the sticky overflow flag.
    assign sum_w    = {1'b0, total_q} + {{(ACC_W + 1 - CW){1'b0}}, acc_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            total_q <= '0;
            ovf_q   <= 1'b0;
`ifdef ONES_COUNTER_MAJORITY_EN
            maj_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        shreg_q <= bus.din;
                        acc_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // start is ignored here; din was captured at acceptance
                    acc_q   <= acc_d;
                    shreg_q <= shreg_q >> STEP;
                    step_q  <= step_q + SW'(1);
                    if (last_grp) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        count_q <= acc_d;
                        total_q <= sum_w[ACC_W-1:0];
                        ovf_q   <= ovf_q | sum_w[ACC_W];
`ifdef ONES_COUNTER_MAJORITY_EN
                        maj_q   <= (acc_d > CW'(WIDTH / 2));
`endif
                    end
                end
                DONE: begin
                    // accepting here gives back-to-back words with no gap
                    if (bus.start) begin
                        shreg_q <= bus.din;
                        acc_q   <= '0;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // Placed last so it overrides a coincident accumulate.
            if (bus.clr_total) begin
                total_q <= '0;
                ovf_q   <= 1'b0;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
    assign bus.total     = total_q;
    assign bus.total_ovf = ovf_q;
`ifdef ONES_COUNTER_MAJORITY_EN
    assign bus.maj       = maj_q;
`endif
endmodule
